// File: rtl/sync_fifo_v2.sv
// rtl/sync_fifo_v2.sv - Parametrised synchronous FIFO with count, thresholds, sticky errors and flush
// Optional first-word-fall-through read path selected by `SYNC_FIFO_FWFT_EN.
module sync_fifo_v2 #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 2048,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             write,
    input  logic [WIDTH-1:0] data_in,
    input  logic             read,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             fifo_full,
    output logic             fifo_not_full,
    output logic             fifo_empty,
    output logic             fifo_not_empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C   = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C   = CW'(AE_LEVEL);
    localparam logic [AW-1:0] LAST_C = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             wr_ok;
    logic             rd_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : p + AW'(1);
    endfunction

    assign fifo_empty     = (count == '0);
    assign fifo_full      = (count == FULL_C);
    assign fifo_not_empty = ~fifo_empty;
    assign fifo_not_full  = ~fifo_full;
    assign almost_full    = (count >= AF_C);
    assign almost_empty   = (count <= AE_C);

    assign wr_ok = write & ~fifo_full & ~clear;
    assign rd_ok = read & ~fifo_empty & ~clear;

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wptr <= bump(wptr);
            end
            if (rd_ok) begin
                rptr <= bump(rptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (write & fifo_full) begin
                overflow <= 1'b1;
            end
            if (read & fifo_empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem[rptr];
    assign rd_valid = fifo_not_empty;
`else
    // data_out holds across idle cycles and clear; only a real pop updates it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else if (clear) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_ok;
            if (rd_ok) begin
                data_out <= mem[rptr];
            end
        end
    end
`endif

endmodule

// File: tb/tb_sync_fifo_v2.sv
// tb/tb_sync_fifo_v2.sv - Randomised queue-model bench for sync_fifo_v2
module tb_sync_fifo_v2;

    localparam int WIDTH = 16;
    localparam int DEPTH = 6;
    localparam int AF    = 4;
    localparam int AE    = 2;
    localparam int CW    = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             write = 1'b0;
    logic             read = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid;
    logic             fifo_full, fifo_not_full, fifo_empty, fifo_not_empty;
    logic             almost_full, almost_empty;
    logic [CW-1:0]    count;
    logic             overflow, underflow;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] exp_do = '0;
    logic             exp_rv = 1'b0;
    logic             exp_ovf = 1'b0;
    logic             exp_udf = 1'b0;

    sync_fifo_v2 #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .write(write), .data_in(data_in),
        .read(read), .data_out(data_out), .rd_valid(rd_valid),
        .fifo_full(fifo_full), .fifo_not_full(fifo_not_full),
        .fifo_empty(fifo_empty), .fifo_not_empty(fifo_not_empty),
        .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string ctx);
        int n;
        n = q.size();
        check({ctx, ".count"}, 32'(count), n);
        check({ctx, ".full"}, 32'(fifo_full), 32'(n == DEPTH));
        check({ctx, ".not_full"}, 32'(fifo_not_full), 32'(n != DEPTH));
        check({ctx, ".empty"}, 32'(fifo_empty), 32'(n == 0));
        check({ctx, ".not_empty"}, 32'(fifo_not_empty), 32'(n != 0));
        check({ctx, ".almost_full"}, 32'(almost_full), 32'(n >= AF));
        check({ctx, ".almost_empty"}, 32'(almost_empty), 32'(n <= AE));
        check({ctx, ".overflow"}, 32'(overflow), 32'(exp_ovf));
        check({ctx, ".underflow"}, 32'(underflow), 32'(exp_udf));
`ifdef SYNC_FIFO_FWFT_EN
        check({ctx, ".rd_valid"}, 32'(rd_valid), 32'(n != 0));
        if (n != 0) check({ctx, ".data_out"}, 32'(data_out), 32'(q[0]));
`else
        check({ctx, ".rd_valid"}, 32'(rd_valid), 32'(exp_rv));
        check({ctx, ".data_out"}, 32'(data_out), 32'(exp_do));
`endif
    endtask

    // Drive one cycle of requests, advance the queue model across the edge, then compare.
    task automatic step(input string ctx, input logic w, input logic r, input logic c,
                        input logic [WIDTH-1:0] d);
        logic full_now, empty_now;
        write = w; read = r; clear = c; data_in = d;
        full_now  = (q.size() == DEPTH);
        empty_now = (q.size() == 0);
        @(posedge clk);
        if (c) begin
            q.delete();
            exp_ovf = 1'b0;
            exp_udf = 1'b0;
            exp_rv  = 1'b0;
        end else begin
            if (w && full_now) exp_ovf = 1'b1;
            if (r && empty_now) exp_udf = 1'b1;
            exp_rv = r && !empty_now;
            if (r && !empty_now) exp_do = q.pop_front();
            if (w && !full_now) q.push_back(d);
        end
        #1;
        write = 1'b0; read = 1'b0; clear = 1'b0;
        check_all(ctx);
    endtask

    initial begin
        #2;
        check("reset.count", 32'(count), 0);
        check("reset.empty", 32'(fifo_empty), 1);
        check("reset.almost_empty", 32'(almost_empty), 1);
        check("reset.rd_valid", 32'(rd_valid), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 1'b0, 1'b0, WIDTH'(16'hA0 + i));
        step("write_full", 1'b1, 1'b0, 1'b0, 16'hBEEF);
        step("rw_full", 1'b1, 1'b1, 1'b0, 16'hCAFE);
        while (q.size() > 0) step("drain", 1'b0, 1'b1, 1'b0, '0);
        step("read_empty", 1'b0, 1'b1, 1'b0, '0);
        step("rw_empty", 1'b1, 1'b1, 1'b0, 16'h1234);
        step("w2", 1'b1, 1'b0, 1'b0, 16'h5678);
        step("rw_cnt2", 1'b1, 1'b1, 1'b0, 16'h9ABC);
        step("rw_cnt2b", 1'b1, 1'b1, 1'b0, 16'hDEF0);
        step("clear_w", 1'b1, 1'b0, 1'b1, 16'h4444);
        step("post_clear_r", 1'b0, 1'b1, 1'b0, '0);

        for (int i = 0; i < 1500; i++) begin
            logic w, r, c;
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 50);
            c = ($urandom_range(0, 99) < 2);
            step("rand", w, r, c, WIDTH'($urandom));
        end

        step("clr", 1'b0, 1'b0, 1'b1, '0);
        for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 1'b0, 1'b0, WIDTH'($urandom));
        #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        exp_ovf = 1'b0; exp_udf = 1'b0; exp_rv = 1'b0; exp_do = '0;
        check_all("async_rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) step("after_rst", 1'b1, 1'b0, 1'b0, WIDTH'(16'h70 + i));
        for (int i = 0; i < 4; i++) step("after_rst_rd", 1'b0, 1'b1, 1'b0, '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
